// File: rtl/oled_frame_ctrl.sv
// OLED frame controller: renders characters from an external glyph ROM into a
// page-organised pixel buffer and streams buffer pages to an SPI byte sender.
module oled_frame_ctrl #(
    parameter  int NUM_PAGES = 4,
    parameter  int NUM_COLS  = 128,
    localparam int AW        = $clog2(NUM_PAGES * NUM_COLS),
    localparam int PW        = $clog2(NUM_PAGES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write_start,
    input  logic [7:0]    write_ascii,
    input  logic [AW-1:0] write_addr,
    output logic          write_ready,
    input  logic          update_start,
    input  logic          update_clear,
    input  logic          update_invert,
    input  logic [PW-1:0] update_first_page,
    input  logic [PW-1:0] update_last_page,
    output logic          update_ready,
    output logic [10:0]   rom_addr,
    input  logic [7:0]    rom_data,
    output logic          spi_start,
    output logic [7:0]    spi_data,
    output logic          spi_dc,
    input  logic          spi_ready,
    output logic          busy,
    output logic [2:0]    o_dbg_state
);

    localparam int DEPTH = NUM_PAGES * NUM_COLS;
    localparam int CW    = $clog2(NUM_COLS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_FETCH = 3'd1,
        S_WR_STORE = 3'd2,
        S_WR_HOLD  = 3'd3,
        S_UP_CMD   = 3'd4,
        S_UP_WAIT  = 3'd5,
        S_UP_DATA  = 3'd6,
        S_UP_HOLD  = 3'd7
    } state_t;

    state_t        r_state;
    logic [7:0]    r_ascii;
    logic [AW-1:0] r_addr;
    logic [2:0]    r_byte_idx;
    logic          r_clear;
    logic          r_invert;
    logic [PW-1:0] r_page;
    logic [PW-1:0] r_last_page;
    logic [CW-1:0] r_col;
    logic [1:0]    r_cmd_idx;
    logic          r_skip;
    logic          r_last_col;
    logic          r_spi_start;
    logic [7:0]    r_spi_data;
    logic          r_spi_dc;
    logic [7:0]    r_mem [0:DEPTH-1];
    logic [7:0]    r_rd_data;

    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;
    logic [7:0]    w_cmd_byte;
    logic [7:0]    w_data_byte;

    assign w_wr_en     = (r_state == S_WR_STORE);
    assign w_wr_addr   = r_addr + AW'(r_byte_idx);
    assign w_rd_addr   = {r_page, r_col};
    assign w_data_byte = r_clear ? 8'h00 : (r_invert ? ~r_rd_data : r_rd_data);

    assign write_ready  = (r_state == S_IDLE) && !write_start;
    assign update_ready = (r_state == S_IDLE) && !update_start;
    assign busy         = (r_state != S_IDLE);
    assign rom_addr     = {r_ascii, r_byte_idx};
    assign spi_start    = r_spi_start;
    assign spi_data     = r_spi_data;
    assign spi_dc       = r_spi_dc;
    assign o_dbg_state  = r_state;

    always_comb begin
        w_cmd_byte = 8'h00;
        case (r_cmd_idx)
            2'd0:    w_cmd_byte = 8'hB0 | 8'(r_page);
            2'd2:    w_cmd_byte = 8'h10;
            default: w_cmd_byte = 8'h00;
        endcase
    end

    // Buffer has no reset so its contents survive an aborted operation.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_addr] <= rom_data;
        r_rd_data <= r_mem[w_rd_addr];
    end

    // SPI handshake: a byte is launched only when spi_ready=1, spi_start pulses
    // one cycle, data/dc hold until spi_ready returns high; the pulse cycle
    // itself is skipped because the sender has not yet dropped spi_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ascii     <= 8'h00;
            r_addr      <= '0;
            r_byte_idx  <= 3'd0;
            r_clear     <= 1'b0;
            r_invert    <= 1'b0;
            r_page      <= '0;
            r_last_page <= '0;
            r_col       <= '0;
            r_cmd_idx   <= 2'd0;
            r_skip      <= 1'b0;
            r_last_col  <= 1'b0;
            r_spi_start <= 1'b0;
            r_spi_data  <= 8'h00;
            r_spi_dc    <= 1'b0;
        end else begin
            r_spi_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (update_start) begin
                        r_clear     <= update_clear;
                        r_invert    <= update_invert;
                        r_page      <= update_first_page;
                        r_last_page <= update_last_page;
                        r_col       <= '0;
                        r_cmd_idx   <= 2'd0;
                        r_state     <= S_UP_CMD;
                    end else if (write_start) begin
                        r_ascii    <= write_ascii;
                        r_addr     <= write_addr;
                        r_byte_idx <= 3'd0;
                        r_state    <= S_WR_FETCH;
                    end
                end
                S_WR_FETCH: r_state <= S_WR_STORE;
                S_WR_STORE: begin
                    r_byte_idx <= r_byte_idx + 3'd1;
                    r_state    <= (r_byte_idx == 3'd7) ? S_WR_HOLD : S_WR_FETCH;
                end
                S_WR_HOLD: if (!write_start) r_state <= S_IDLE;
                S_UP_CMD: begin
                    if (spi_ready) begin
                        r_spi_start <= 1'b1;
                        r_spi_data  <= w_cmd_byte;
                        r_spi_dc    <= 1'b0;
                        r_skip      <= 1'b1;
                        r_state     <= S_UP_WAIT;
                    end
                end
                S_UP_DATA: begin
                    if (spi_ready) begin
                        r_spi_start <= 1'b1;
                        r_spi_data  <= w_data_byte;
                        r_spi_dc    <= 1'b1;
                        r_skip      <= 1'b1;
                        // Advance early so the next read address is settled a cycle ahead.
                        r_last_col  <= (r_col == CW'(NUM_COLS - 1));
                        r_col       <= r_col + 1'b1;
                        r_state     <= S_UP_WAIT;
                    end
                end
                S_UP_WAIT: begin
                    if (r_skip) begin
                        r_skip <= 1'b0;
                    end else if (spi_ready) begin
                        if (!r_spi_dc) begin
                            if (r_cmd_idx == 2'd2) begin
                                r_cmd_idx <= 2'd0;
                                r_state   <= S_UP_DATA;
                            end else begin
                                r_cmd_idx <= r_cmd_idx + 2'd1;
                                r_state   <= S_UP_CMD;
                            end
                        end else if (!r_last_col) begin
                            r_state <= S_UP_DATA;
                        end else if (r_page == r_last_page) begin
                            r_state <= S_UP_HOLD;
                        end else begin
                            r_page  <= r_page + 1'b1;
                            r_state <= S_UP_CMD;
                        end
                    end
                end
                S_UP_HOLD: if (!update_start) r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_frame_ctrl.sv
// Directed bench for oled_frame_ctrl: glyph ROM and SPI sender models, a buffer
// model, and an expected-byte queue checked on every SPI transfer.
module tb_oled_frame_ctrl;

    localparam int NP    = 4;
    localparam int NC    = 128;
    localparam int DEPTH = NP * NC;
    localparam int AW    = 9;
    localparam int PW    = 2;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_FETCH = 3'd1;
    localparam logic [2:0] ST_WR_HOLD  = 3'd3;
    localparam logic [2:0] ST_UP_CMD   = 3'd4;
    localparam logic [2:0] ST_UP_HOLD  = 3'd7;

    logic          clk;
    logic          rst;
    logic          write_start;
    logic [7:0]    write_ascii;
    logic [AW-1:0] write_addr;
    logic          write_ready;
    logic          update_start;
    logic          update_clear;
    logic          update_invert;
    logic [PW-1:0] update_first_page;
    logic [PW-1:0] update_last_page;
    logic          update_ready;
    logic [10:0]   rom_addr;
    logic [7:0]    rom_data;
    logic          spi_start;
    logic [7:0]    spi_data;
    logic          spi_dc;
    logic          spi_ready;
    logic          busy;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    int data_cnt  = 0;
    int proto_err = 0;
    logic [8:0] exp_q[$];
    logic [8:0] cap;
    logic [2:0] rdy_cnt;
    logic [7:0] buf_m [0:DEPTH-1];

    oled_frame_ctrl #(.NUM_PAGES(NP), .NUM_COLS(NC)) dut (
        .clk(clk), .rst(rst),
        .write_start(write_start), .write_ascii(write_ascii),
        .write_addr(write_addr), .write_ready(write_ready),
        .update_start(update_start), .update_clear(update_clear),
        .update_invert(update_invert), .update_first_page(update_first_page),
        .update_last_page(update_last_page), .update_ready(update_ready),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .spi_start(spi_start), .spi_data(spi_data), .spi_dc(spi_dc),
        .spi_ready(spi_ready), .busy(busy), .o_dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] glyph(input logic [7:0] ascii, input logic [2:0] idx);
        return {ascii[3:0], 1'b0, idx};
    endfunction

    // Glyph ROM with one cycle of read latency.
    always @(posedge clk) rom_data <= glyph(rom_addr[10:3], rom_addr[2:0]);

    // SPI sender: drops ready on a start, raises it again three cycles later.
    always @(posedge clk) begin
        if (rst) begin
            spi_ready <= 1'b1;
            rdy_cnt   <= 3'd0;
        end else if (!spi_ready) begin
            if ({spi_dc, spi_data} !== cap) proto_err++;
            if (spi_start) proto_err++;
            if (rdy_cnt == 3'd1) spi_ready <= 1'b1;
            rdy_cnt <= rdy_cnt - 3'd1;
        end else if (spi_start) begin
            cap = {spi_dc, spi_data};
            spi_ready <= 1'b0;
            rdy_cnt   <= 3'd3;
            if (spi_dc) data_cnt++;
            if (exp_q.size() == 0) check("spi_extra_byte", exp_q.size(), 1);
            else check("spi_byte", cap, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] ascii, input int addr);
        int n;
        check("wr_ready_idle", write_ready, 1);
        write_ascii = ascii;
        write_addr  = AW'(addr);
        write_start = 1'b1;
        tick();
        check("wr_accept", dbg_state, ST_WR_FETCH);
        write_ascii = ~ascii;
        write_addr  = write_addr + 9'd37;
        n = 0;
        while (dbg_state != ST_WR_HOLD && n < 64) begin
            tick();
            n++;
        end
        check("wr_latency", n, 16);
        write_start = 1'b0;
        tick();
        check("wr_release", dbg_state, ST_IDLE);
        for (int i = 0; i < 8; i++) buf_m[(addr + i) % DEPTH] = glyph(ascii, 3'(i));
    endtask

    task automatic push_expected(input int first, input int last, input bit clr, input bit inv);
        int p;
        logic [7:0] d;
        p = first;
        for (int k = 0; k < NP; k++) begin
            exp_q.push_back({1'b0, 8'hB0 | 8'(p)});
            exp_q.push_back(9'h000);
            exp_q.push_back(9'h010);
            for (int c = 0; c < NC; c++) begin
                d = buf_m[p * NC + c];
                if (clr) d = 8'h00;
                else if (inv) d = ~d;
                exp_q.push_back({1'b1, d});
            end
            if (p == last) break;
            p = (p + 1) % NP;
        end
    endtask

    task automatic wait_up_hold(input string tag);
        int n;
        n = 0;
        while (dbg_state != ST_UP_HOLD && n < 5000) begin
            tick();
            n++;
        end
        check(tag, dbg_state, ST_UP_HOLD);
        check("up_drain", exp_q.size(), 0);
    endtask

    task automatic do_update(input logic [1:0] first, input logic [1:0] last, input bit clr, input bit inv);
        push_expected(first, last, clr, inv);
        check("up_ready_idle", update_ready, 1);
        update_first_page = first;
        update_last_page  = last;
        update_clear      = clr;
        update_invert     = inv;
        update_start      = 1'b1;
        tick();
        check("up_accept", dbg_state, ST_UP_CMD);
        update_first_page = first + 2'd1;
        update_last_page  = last + 2'd1;
        update_clear      = ~clr;
        update_invert     = ~inv;
        wait_up_hold("up_hold_reached");
        update_start = 1'b0;
        tick();
        check("up_release", dbg_state, ST_IDLE);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        rst = 1'b1;
        write_start = 1'b0; write_ascii = 8'h00; write_addr = '0;
        update_start = 1'b0; update_clear = 1'b0; update_invert = 1'b0;
        update_first_page = '0; update_last_page = '0;
        #1;
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_spi_start", spi_start, 0);
        check("rst_spi_data", spi_data, 8'h00);
        check("rst_spi_dc", spi_dc, 0);
        check("rst_rom_addr", rom_addr, 11'h000);
        check("rst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_wr_ready", write_ready, 1);
        check("rst_up_ready", update_ready, 1);

        // Fill the whole buffer so every byte has a known value.
        for (int k = 0; k < DEPTH / 8; k++) do_write(8'(k * 29 + 5), k * 8);
        do_write(8'h41, 0);
        do_write(8'h37, DEPTH - 4);

        do_update(2'd1, 2'd1, 1'b0, 1'b0);
        do_update(2'd3, 2'd0, 1'b0, 1'b1);
        do_update(2'd3, 2'd0, 1'b1, 1'b1);
        do_update(2'd2, 2'd3, 1'b0, 1'b0);

        // Simultaneous start: update wins, write waits for its return to idle.
        push_expected(2, 2, 1'b0, 1'b0);
        write_ascii = 8'h42; write_addr = 9'd260; write_start = 1'b1;
        update_first_page = 2'd2; update_last_page = 2'd2;
        update_clear = 1'b0; update_invert = 1'b0; update_start = 1'b1;
        tick();
        check("both_update_wins", dbg_state, ST_UP_CMD);
        check("both_wr_blocked", write_ready, 0);
        wait_up_hold("both_up_hold");
        check("both_still_hold", dbg_state, ST_UP_HOLD);
        update_start = 1'b0;
        tick();
        check("both_back_idle", dbg_state, ST_IDLE);
        tick();
        check("both_wr_accept", dbg_state, ST_WR_FETCH);
        n = 0;
        while (dbg_state != ST_WR_HOLD && n < 64) begin
            tick();
            n++;
        end
        check("both_wr_latency", n, 16);
        write_start = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) buf_m[260 + i] = glyph(8'h42, 3'(i));
        do_update(2'd2, 2'd2, 1'b0, 1'b0);

        // Reset in the middle of the 50th data byte of a full-screen update.
        push_expected(0, 3, 1'b0, 1'b0);
        update_first_page = 2'd0; update_last_page = 2'd3;
        update_clear = 1'b0; update_invert = 1'b0; update_start = 1'b1;
        base = data_cnt;
        tick();
        n = 0;
        while (!(spi_start && spi_dc && (data_cnt - base) == 49) && n < 5000) begin
            tick();
            n++;
        end
        check("abort_found_byte50", data_cnt - base, 49);
        rst = 1'b1;
        #1;
        check("abort_spi_start", spi_start, 0);
        check("abort_state", dbg_state, ST_IDLE);
        check("abort_busy", busy, 0);
        check("abort_spi_data", spi_data, 8'h00);
        check("abort_rom_addr", rom_addr, 11'h000);
        exp_q.delete();
        update_start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("abort_wr_ready", write_ready, 1);
        check("abort_up_ready", update_ready, 1);
        do_update(2'd0, 2'd1, 1'b0, 1'b0);

        check("spi_protocol", proto_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
